// File: rtl/crt_pkg.sv
// rtl/crt_pkg.sv - shared widths, register map, masks and access FSM encoding for the CRT register port
package crt_pkg;

  localparam int IDX_WIDTH  = 4;
  localparam int DATA_WIDTH = 8;
  localparam int NUM_REGS   = 16;

  localparam logic [IDX_WIDTH-1:0] R_HTOTAL       = 4'd0;
  localparam logic [IDX_WIDTH-1:0] R_HDISP        = 4'd1;
  localparam logic [IDX_WIDTH-1:0] R_HSYNC_POS    = 4'd2;
  localparam logic [IDX_WIDTH-1:0] R_SYNC_WIDTH   = 4'd3;
  localparam logic [IDX_WIDTH-1:0] R_VTOTAL       = 4'd4;
  localparam logic [IDX_WIDTH-1:0] R_VTOTAL_ADJ   = 4'd5;
  localparam logic [IDX_WIDTH-1:0] R_VDISP        = 4'd6;
  localparam logic [IDX_WIDTH-1:0] R_VSYNC_POS    = 4'd7;
  localparam logic [IDX_WIDTH-1:0] R_INTERLACE    = 4'd8;
  localparam logic [IDX_WIDTH-1:0] R_MAX_SCANLINE = 4'd9;
  localparam logic [IDX_WIDTH-1:0] R_CURSOR_START = 4'd10;
  localparam logic [IDX_WIDTH-1:0] R_CURSOR_END   = 4'd11;
  localparam logic [IDX_WIDTH-1:0] R_START_H      = 4'd12;
  localparam logic [IDX_WIDTH-1:0] R_START_L      = 4'd13;
  localparam logic [IDX_WIDTH-1:0] R_CURSOR_H     = 4'd14;
  localparam logic [IDX_WIDTH-1:0] R_CURSOR_L     = 4'd15;

  // Raster geometry (R0..R9) is frame-synchronous; cursor/start address (R12..R15) are CPU-visible.
  localparam logic [NUM_REGS-1:0] DEFAULT_DEFER_MASK = 16'h03FF;
  localparam logic [NUM_REGS-1:0] DEFAULT_READ_MASK  = 16'hF000;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    ACK          = 2'd1,
    WAIT_RELEASE = 2'd2
  } access_state_t;

endpackage

// File: rtl/crt_address_decoder.sv
// rtl/crt_address_decoder.sv - index to one-hot select decode, all zeros when not selected
module crt_address_decoder #(
  parameter int ADDR_WIDTH = 4
) (
  input  logic                         cs,
  input  logic [ADDR_WIDTH-1:0]        addr,
  output logic [(1<<ADDR_WIDTH)-1:0]   sel
);

  always_comb begin
    sel = '0;
    if (cs) sel[addr] = 1'b1;
  end

endmodule

// File: rtl/crt_register_interface.sv
// rtl/crt_register_interface.sv - 6845-style index/data register port with frame-synchronous commit
module crt_register_interface
  import crt_pkg::*;
#(
  parameter int                   DATA_WIDTH = crt_pkg::DATA_WIDTH,
  parameter int                   IDX_WIDTH  = crt_pkg::IDX_WIDTH,
  parameter logic [NUM_REGS-1:0]  DEFER_MASK = DEFAULT_DEFER_MASK,
  parameter logic [NUM_REGS-1:0]  READ_MASK  = DEFAULT_READ_MASK
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           bus_cs,
  input  logic                           bus_rs,
  input  logic                           bus_we,
  input  logic                           bus_re,
  input  logic [DATA_WIDTH-1:0]          bus_wdata,
  output logic [DATA_WIDTH-1:0]          bus_rdata,
  output logic                           bus_ack,
  input  logic                           frame_start,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_update,
  output logic                           cfg_pending,
  output logic [IDX_WIDTH-1:0]           index_q
);

  access_state_t         state;
  logic [DATA_WIDTH-1:0] live   [NUM_REGS];
  logic [DATA_WIDTH-1:0] shadow [NUM_REGS];
  logic [NUM_REGS-1:0]   pending;
  logic [NUM_REGS-1:0]   wr_sel;
  logic [NUM_REGS-1:0]   defer_wr;
  logic [NUM_REGS-1:0]   imm_wr;
  logic [NUM_REGS-1:0]   commit;
  logic [NUM_REGS-1:0]   pending_next;
  logic [DATA_WIDTH-1:0] rd_val;
  logic                  access;
  logic                  data_wr;

  assign access  = bus_cs & (bus_we | bus_re);
  assign data_wr = (state == IDLE) & bus_cs & bus_we & bus_rs;

  crt_address_decoder #(
    .ADDR_WIDTH (IDX_WIDTH)
  ) u_decoder (
    .cs   (data_wr),
    .addr (index_q),
    .sel  (wr_sel)
  );

  // A commit in the same cycle as a deferred write clears the old pending bit and the
  // write re-arms it, so the new shadow value waits for the next frame.
  always_comb begin
    defer_wr     = wr_sel & DEFER_MASK;
    imm_wr       = wr_sel & ~DEFER_MASK;
    commit       = frame_start ? pending : '0;
    pending_next = (pending & ~commit) | defer_wr;
    rd_val       = READ_MASK[index_q] ? live[index_q] : '0;
  end

  always_comb begin
    reg_q = '0;
    for (int i = 0; i < NUM_REGS; i++) reg_q[i*DATA_WIDTH +: DATA_WIDTH] = live[i];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      bus_ack   <= 1'b0;
      bus_rdata <= '0;
      index_q   <= '0;
    end else begin
      bus_ack <= 1'b0;
      case (state)
        IDLE: begin
          if (access) begin
            state   <= ACK;
            bus_ack <= 1'b1;
            if (bus_we) begin
              bus_rdata <= '0;
              if (!bus_rs) index_q <= bus_wdata[IDX_WIDTH-1:0];
            end else begin
              bus_rdata <= bus_rs ? rd_val : '0;
            end
          end
        end
        ACK:          state <= WAIT_RELEASE;
        WAIT_RELEASE: if (!access) state <= IDLE;
        default:      state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        live[i]   <= '0;
        shadow[i] <= '0;
      end
      pending     <= '0;
      reg_update  <= '0;
      cfg_pending <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (commit[i])   live[i]   <= shadow[i];
        if (imm_wr[i])   live[i]   <= bus_wdata;
        if (defer_wr[i]) shadow[i] <= bus_wdata;
      end
      pending     <= pending_next;
      reg_update  <= imm_wr | commit;
      cfg_pending <= |pending_next;
    end
  end

endmodule

// File: doc/crt_register_interface.md
Name: crt_register_interface

Overview:
- CPU-facing index/data register port for the CRT controller, 6845-style.
- The CPU writes a register index to the index port, then reads or writes that register through the data port.
- Holds all 16 controller registers and drives them to the timing generator.
- Timing registers are double-buffered and commit only at frame start, so raster geometry never changes mid-frame.
- Cursor and start-address registers take effect immediately.

Parameters:
- DATA_WIDTH, 8, width of each register and of the bus data.
- IDX_WIDTH, 4, index width; 2**IDX_WIDTH registers.
- DEFER_MASK, 16'h03FF, bit i=1 means register i is double-buffered (commit at frame_start).
- READ_MASK, 16'hF000, bit i=1 means register i is readable; others read 0.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- bus_cs  in  1  chip select
- bus_rs  in  1  register select: 0 = index port, 1 = data port
- bus_we  in  1  write strobe, level, qualified by bus_cs
- bus_re  in  1  read strobe, level, qualified by bus_cs
- bus_wdata  in  DATA_WIDTH  write data
- bus_rdata  out  DATA_WIDTH  read data, valid while bus_ack=1
- bus_ack  out  1  one-cycle access acknowledge
- frame_start  in  1  one-cycle pulse from the timing generator at the first pixel of a frame
- reg_q  out  16*DATA_WIDTH  live register values, register i at bits [i*DATA_WIDTH +: DATA_WIDTH]
- reg_update  out  16  one-hot/multi-hot pulse; bit i is set for one cycle when live register i changes
- cfg_pending  out  1  at least one deferred write is awaiting commit
- index_q  out  IDX_WIDTH  current index register

Behaviour:
- Reset (synchronous, rst=1 at a clk edge) clears:
  - index_q, all live and shadow registers, the pending mask;
  - bus_ack, bus_rdata, reg_update, cfg_pending.
  - The FSM goes to IDLE.
  - Reset overrides any in-flight access or commit.
- Access FSM:
  - IDLE: on bus_cs & (bus_we|bus_re), perform the access, go to ACK. If both strobes are set, the write wins.
  - ACK: bus_ack=1 for exactly this cycle; bus_rdata holds the read value. Go to WAIT_RELEASE.
  - WAIT_RELEASE: stay until !(bus_cs & (bus_we|bus_re)), then go to IDLE. A held strobe produces exactly one access.
  - Minimum access-to-access spacing is 3 cycles.
- Index write (rs=0, we): index_q <= bus_wdata[IDX_WIDTH-1:0]; upper bits are ignored.
- Index read (rs=0, re): bus_rdata = 0 (index is write-only).
- Data write (rs=1, we), with i = index_q:
  - Decode index_q to one-hot through the decoder submodule.
  - DEFER_MASK[i]=1: shadow[i] <= wdata and pending[i] <= 1; the live value is unchanged.
  - DEFER_MASK[i]=0: live[i] <= wdata; reg_update[i] pulses the following cycle.
- Data read (rs=1, re): bus_rdata = READ_MASK[index_q] ? live[index_q] : 0. Reads return the live value, never the shadow.
- Commit:
  - On frame_start=1 with pending≠0: live[i] <= shadow[i] for every pending i.
  - reg_update = pending for one cycle; pending then clears.
  - frame_start with pending=0 has no effect.
- Simultaneous deferred write and frame_start in the same cycle:
  - The commit uses the shadow value from before the write.
  - The written register ends pending=1 with the new shadow, and commits at the next frame_start.
  - A rewrite of an already-pending register only replaces the shadow.
- Simultaneous immediate write and frame_start: both take effect; reg_update is the OR of both sources.
- cfg_pending = |pending, registered, so it updates 1 cycle after the cause.
- reg_q is registered with no combinational path from the bus.

Decomposition:
- Shared package crt_pkg holds:
  - IDX_WIDTH, DATA_WIDTH, NUM_REGS=16;
  - register index constants (R_HTOTAL=0 … R_CURSOR_L=15);
  - default DEFER_MASK and READ_MASK;
  - access FSM state encoding (IDLE, ACK, WAIT_RELEASE).
- One sub-module: the existing crt_address_decoder, instantiated for the index→one-hot write-enable decode, with cs = data-write qualifier.

Test Plan:
- Reset with rst=1 for 2 cycles mid-access → bus_ack=0, reg_q=0, cfg_pending=0, FSM in IDLE; the next access acks normally.
- Write index 4'hE, then data 8'h5A (immediate register):
  - live[14]=8'h5A one cycle after the data-write acceptance; reg_update=16'h4000 for one cycle;
  - data read returns 8'h5A with bus_ack for exactly 1 cycle.
- Write index 0, data 8'h63 (deferred):
  - reg_q[7:0] stays 0 and cfg_pending=1;
  - after frame_start: reg_q[7:0]=8'h63, reg_update=16'h0001, cfg_pending=0.
- Hold bus_we asserted 20 cycles on the data port → exactly one write and one bus_ack pulse.
- Write index 1, data 8'h50 in the same cycle as frame_start (reg 1 previously pending with 8'h4F):
  - 8'h4F commits and reg 1 stays pending;
  - 8'h50 commits at the next frame_start.
- Write index 8'hF3 (upper bits set) → index_q=4'h3. Reads of registers 0–11 → bus_rdata=0.
